id_ex_pipe_reg: RTL and testbench

ID/EX pipeline register and load-use hazard unit for the 5-stage RISC-V core. It captures decoded operands and controller outputs from ID and presents them to the EX stage one cycle later. It also detects load-use hazards and inserts bubbles. It honours a branch flush from EX and a downstream stall from MEM.

---
 rtl/id_ex_pipe_reg_if.sv | 64 ++++++
 rtl/id_ex_pipe_reg.sv | 121 ++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX boundary bundle: decoded ID fields in, registered EX fields out,
// plus the flush/stall controls and the upstream hold request.
interface id_ex_pipe_reg_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [XLEN-1:0]   id_pc;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic [2:0]        id_funct3;
  logic [XLEN-1:0]   id_rdata1;
  logic [XLEN-1:0]   id_rdata2;
  logic [XLEN-1:0]   id_imm;
  logic              id_Branch;
  logic              id_MemREAD;
  logic              id_MemtoReg;
  logic              id_ALUSrc;
  logic              id_RegWrite;
  logic              id_PCSrc;
  logic [1:0]        id_MemWrite;
  logic [4:0]        id_ALUOp;

  logic              flush_i;
  logic              ex_stall_i;
  logic              id_hold_o;

  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc;
  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic [2:0]        ex_funct3;
  logic [XLEN-1:0]   ex_rdata1;
  logic [XLEN-1:0]   ex_rdata2;
  logic [XLEN-1:0]   ex_imm;
  logic              ex_Branch;
  logic              ex_MemREAD;
  logic              ex_MemtoReg;
  logic              ex_ALUSrc;
  logic              ex_RegWrite;
  logic              ex_PCSrc;
  logic [1:0]        ex_MemWrite;
  logic [4:0]        ex_ALUOp;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_funct3, id_rdata1, id_rdata2, id_imm,
           id_Branch, id_MemREAD, id_MemtoReg, id_ALUSrc, id_RegWrite, id_PCSrc, id_MemWrite,
           id_ALUOp, flush_i, ex_stall_i,
    input  id_hold_o, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_rdata1, ex_rdata2,
           ex_imm, ex_Branch, ex_MemREAD, ex_MemtoReg, ex_ALUSrc, ex_RegWrite, ex_PCSrc,
           ex_MemWrite, ex_ALUOp
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_funct3, id_rdata1, id_rdata2, id_imm,
           id_Branch, id_MemREAD, id_MemtoReg, id_ALUSrc, id_RegWrite, id_PCSrc, id_MemWrite,
           id_ALUOp, flush_i, ex_stall_i,
    output id_hold_o, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_rdata1, ex_rdata2,
           ex_imm, ex_Branch, ex_MemREAD, ex_MemtoReg, ex_ALUSrc, ex_RegWrite, ex_PCSrc,
           ex_MemWrite, ex_ALUOp
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use bubble insertion, EX flush and MEM stall.
// Optional HAZARD_PERF_EN adds saturating load-use and flush event counters.
module id_ex_pipe_reg #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic                clk,
  input  logic                rst,
  id_ex_pipe_reg_if.slave     bus
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]         perf_lu_cnt,
  output logic [31:0]         perf_flush_cnt
`endif
);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [2:0]        funct3;
    logic [XLEN-1:0]   rdata1;
    logic [XLEN-1:0]   rdata2;
    logic [XLEN-1:0]   imm;
    logic              branch;
    logic              mem_read;
    logic              mem_to_reg;
    logic              alu_src;
    logic              reg_write;
    logic              pc_src;
    logic [1:0]        mem_write;
    logic [4:0]        alu_op;
  } payload_t;

  payload_t id_p;
  payload_t ex_q;
  logic     ex_valid_q;
  logic     hz;
  logic     do_flush;
  logic     do_hold;
  logic     do_bubble;

  always_comb begin
    id_p = '{
      pc:         bus.id_pc,
      rs1:        bus.id_rs1,
      rs2:        bus.id_rs2,
      rd:         bus.id_rd,
      funct3:     bus.id_funct3,
      rdata1:     bus.id_rdata1,
      rdata2:     bus.id_rdata2,
      imm:        bus.id_imm,
      branch:     bus.id_Branch,
      mem_read:   bus.id_MemREAD,
      mem_to_reg: bus.id_MemtoReg,
      alu_src:    bus.id_ALUSrc,
      reg_write:  bus.id_RegWrite,
      pc_src:     bus.id_PCSrc,
      mem_write:  bus.id_MemWrite,
      alu_op:     bus.id_ALUOp
    };
  end

  // Both sources compared even if the instruction ignores rs2; x0 never hazards.
  assign hz = ex_valid_q & ex_q.mem_read & (ex_q.rd != '0) & bus.id_valid &
              ((ex_q.rd == bus.id_rs1) | (ex_q.rd == bus.id_rs2));

  assign do_flush  = bus.flush_i;
  assign do_hold   = ~bus.flush_i & bus.ex_stall_i;
  assign do_bubble = ~bus.flush_i & ~bus.ex_stall_i & hz;

  assign bus.id_hold_o = ~bus.flush_i & (bus.ex_stall_i | hz);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
    end else if (do_flush || do_bubble) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
    end else if (!do_hold) begin
      ex_valid_q <= bus.id_valid;
      ex_q       <= bus.id_valid ? id_p : '0;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_lu_cnt    <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (do_bubble && (perf_lu_cnt != 32'hFFFF_FFFF))
        perf_lu_cnt <= perf_lu_cnt + 32'd1;
      // Flushing an already-empty pipe is not counted.
      if (do_flush && (ex_valid_q || bus.id_valid) && (perf_flush_cnt != 32'hFFFF_FFFF))
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_pc       = ex_q.pc;
  assign bus.ex_rs1      = ex_q.rs1;
  assign bus.ex_rs2      = ex_q.rs2;
  assign bus.ex_rd       = ex_q.rd;
  assign bus.ex_funct3   = ex_q.funct3;
  assign bus.ex_rdata1   = ex_q.rdata1;
  assign bus.ex_rdata2   = ex_q.rdata2;
  assign bus.ex_imm      = ex_q.imm;
  assign bus.ex_Branch   = ex_q.branch;
  assign bus.ex_MemREAD  = ex_q.mem_read;
  assign bus.ex_MemtoReg = ex_q.mem_to_reg;
  assign bus.ex_ALUSrc   = ex_q.alu_src;
  assign bus.ex_RegWrite = ex_q.reg_write;
  assign bus.ex_PCSrc    = ex_q.pc_src;
  assign bus.ex_MemWrite = ex_q.mem_write;
  assign bus.ex_ALUOp    = ex_q.alu_op;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed scenarios plus a randomized
// run against a transaction-level model of the ID/EX register.
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] imm;
    logic        branch;
    logic        memread;
    logic        memtoreg;
    logic        alusrc;
    logic        regwrite;
    logic        pcsrc;
    logic [1:0]  memwrite;
    logic [4:0]  aluop;
  } fields_t;

  logic    clk = 1'b0;
  logic    rst = 1'b0;
  fields_t in_f = '0;
  logic    in_valid = 1'b0;
  logic    in_flush = 1'b0;
  logic    in_stall = 1'b0;

  // Reference: contents of EX as an instruction record, plus event counts.
  logic    m_valid;
  fields_t m_f;
  int unsigned m_lu;
  int unsigned m_fl;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] perf_lu;
  logic [31:0] perf_fl;

  id_ex_pipe_reg_if #(.XLEN(32), .REG_AW(5)) bus ();

  id_ex_pipe_reg #(.XLEN(32), .REG_AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef HAZARD_PERF_EN
    ,
    .perf_lu_cnt    (perf_lu),
    .perf_flush_cnt (perf_fl)
`endif
  );

`ifndef HAZARD_PERF_EN
  assign perf_lu = '0;
  assign perf_fl = '0;
`endif

  always #5 clk = ~clk;

  assign bus.id_valid    = in_valid;
  assign bus.id_pc       = in_f.pc;
  assign bus.id_rs1      = in_f.rs1;
  assign bus.id_rs2      = in_f.rs2;
  assign bus.id_rd       = in_f.rd;
  assign bus.id_funct3   = in_f.funct3;
  assign bus.id_rdata1   = in_f.rdata1;
  assign bus.id_rdata2   = in_f.rdata2;
  assign bus.id_imm      = in_f.imm;
  assign bus.id_Branch   = in_f.branch;
  assign bus.id_MemREAD  = in_f.memread;
  assign bus.id_MemtoReg = in_f.memtoreg;
  assign bus.id_ALUSrc   = in_f.alusrc;
  assign bus.id_RegWrite = in_f.regwrite;
  assign bus.id_PCSrc    = in_f.pcsrc;
  assign bus.id_MemWrite = in_f.memwrite;
  assign bus.id_ALUOp    = in_f.aluop;
  assign bus.flush_i     = in_flush;
  assign bus.ex_stall_i  = in_stall;

  function automatic fields_t ex_fields();
    fields_t f;
    f.pc = bus.ex_pc;         f.rs1 = bus.ex_rs1;       f.rs2 = bus.ex_rs2;
    f.rd = bus.ex_rd;         f.funct3 = bus.ex_funct3; f.rdata1 = bus.ex_rdata1;
    f.rdata2 = bus.ex_rdata2; f.imm = bus.ex_imm;       f.branch = bus.ex_Branch;
    f.memread = bus.ex_MemREAD;   f.memtoreg = bus.ex_MemtoReg;
    f.alusrc = bus.ex_ALUSrc;     f.regwrite = bus.ex_RegWrite;
    f.pcsrc = bus.ex_PCSrc;       f.memwrite = bus.ex_MemWrite;
    f.aluop = bus.ex_ALUOp;
    return f;
  endfunction

  function automatic fields_t rand_fields();
    fields_t f;
    f = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return f;
  endfunction

  function automatic logic model_hazard();
    return m_valid && m_f.memread && (m_f.rd != 5'd0) && in_valid &&
           (m_f.rd == in_f.rs1 || m_f.rd == in_f.rs2);
  endfunction

  // Advance the model by one rising edge using the priority rules, then let the DUT clock.
  task automatic tick();
    logic    hz;
    logic    n_valid;
    fields_t n_f;
    hz = model_hazard();
    n_valid = m_valid;
    n_f = m_f;
    if (in_flush) begin
      if (m_valid || in_valid) m_fl = (m_fl == 32'hFFFF_FFFF) ? m_fl : m_fl + 1;
      n_valid = 1'b0; n_f = '0;
    end else if (in_stall) begin
      n_valid = m_valid;
    end else if (hz) begin
      m_lu = (m_lu == 32'hFFFF_FFFF) ? m_lu : m_lu + 1;
      n_valid = 1'b0; n_f = '0;
    end else if (in_valid) begin
      n_valid = 1'b1; n_f = in_f;
    end else begin
      n_valid = 1'b0; n_f = '0;
    end
    @(posedge clk);
    m_valid = n_valid;
    m_f = n_f;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    in_valid = 1'b0; in_flush = 1'b0; in_stall = 1'b0; in_f = '0;
    rst = 1'b1;
    m_valid = 1'b0; m_f = '0; m_lu = 0; m_fl = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++;
    if (bus.ex_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b want 0", bus.ex_valid);
    end
    n_tests++;
    if (ex_fields() !== fields_t'(0)) begin
      n_fail++; $display("FAIL reset_fields: got %h want 0", ex_fields());
    end
    n_tests++;
    if (bus.id_hold_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_hold: got %b want 0", bus.id_hold_o);
    end
  endtask

  task automatic test_basic();
    fields_t f;
    apply_reset();
    in_f = '0; in_f.pc = 32'h100; in_f.rd = 5'd5; in_f.regwrite = 1'b1; in_valid = 1'b1;
    #1;
    n_tests++;
    if (bus.id_hold_o !== 1'b0) begin
      n_fail++; $display("FAIL basic_hold: got %b want 0", bus.id_hold_o);
    end
    tick();
    f = ex_fields();
    n_tests++;
    if (bus.ex_valid !== 1'b1 || f.pc !== 32'h100 || f.rd !== 5'd5 || f.regwrite !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_load: got v=%b pc=%h rd=%0d rw=%b want v=1 pc=100 rd=5 rw=1",
               bus.ex_valid, f.pc, f.rd, f.regwrite);
    end
  endtask

  task automatic set_load();
    in_f = '0; in_f.pc = 32'h200; in_f.rd = 5'd5; in_f.memread = 1'b1;
    in_f.memtoreg = 1'b1; in_f.regwrite = 1'b1; in_f.alusrc = 1'b1; in_f.funct3 = 3'd2;
    in_valid = 1'b1;
  endtask

  task automatic set_add(input logic [4:0] rs1);
    in_f = '0; in_f.pc = 32'h204; in_f.rs1 = rs1; in_f.rs2 = 5'd6; in_f.rd = 5'd7;
    in_f.regwrite = 1'b1; in_f.aluop = 5'd1; in_f.rdata1 = 32'h1111; in_f.rdata2 = 32'h2222;
    in_valid = 1'b1;
  endtask

  task automatic test_load_use();
    apply_reset();
    set_load();
    tick();
    set_add(5'd5);
    #1;
    n_tests++;
    if (bus.id_hold_o !== 1'b1) begin
      n_fail++; $display("FAIL lu_hold: got %b want 1", bus.id_hold_o);
    end
    tick();
    n_tests++;
    if (bus.ex_valid !== 1'b0 || ex_fields() !== fields_t'(0)) begin
      n_fail++; $display("FAIL lu_bubble: got v=%b f=%h want v=0 f=0", bus.ex_valid, ex_fields());
    end
    n_tests++;
    if (bus.id_hold_o !== 1'b0) begin
      n_fail++; $display("FAIL lu_release: got %b want 0", bus.id_hold_o);
    end
    tick();
    n_tests++;
    if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 32'h204 || bus.ex_rd !== 5'd7) begin
      n_fail++;
      $display("FAIL lu_advance: got v=%b pc=%h rd=%0d want v=1 pc=204 rd=7",
               bus.ex_valid, bus.ex_pc, bus.ex_rd);
    end
`ifdef HAZARD_PERF_EN
    n_tests++;
    if (perf_lu !== 32'd1 || perf_fl !== 32'd0) begin
      n_fail++; $display("FAIL lu_perf: got lu=%0d fl=%0d want lu=1 fl=0", perf_lu, perf_fl);
    end
`endif
  endtask

  task automatic test_x0();
    apply_reset();
    set_load();
    in_f.rd = 5'd0;
    tick();
    set_add(5'd0);
    in_f.rs2 = 5'd0;
    #1;
    n_tests++;
    if (bus.id_hold_o !== 1'b0) begin
      n_fail++; $display("FAIL x0_hold: got %b want 0", bus.id_hold_o);
    end
    tick();
    n_tests++;
    if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 32'h204) begin
      n_fail++; $display("FAIL x0_advance: got v=%b pc=%h want v=1 pc=204", bus.ex_valid, bus.ex_pc);
    end
  endtask

  task automatic test_stall();
    fields_t alu;
    apply_reset();
    set_add(5'd3);
    alu = in_f;
    tick();
    in_f = rand_fields(); in_f.pc = 32'h300; in_f.memread = 1'b0;
    in_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (bus.id_hold_o !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got %b want 1", i, bus.id_hold_o);
      end
      tick();
      n_tests++;
      if (bus.ex_valid !== 1'b1 || ex_fields() !== alu) begin
        n_fail++;
        $display("FAIL stall_keep[%0d]: got v=%b f=%h want v=1 f=%h", i, bus.ex_valid, ex_fields(), alu);
      end
    end
    in_stall = 1'b0;
    tick();
    n_tests++;
    if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 32'h300) begin
      n_fail++; $display("FAIL stall_release: got v=%b pc=%h want v=1 pc=300", bus.ex_valid, bus.ex_pc);
    end
  endtask

  task automatic test_flush_priority();
    apply_reset();
    set_load();
    in_f.memwrite = 2'b11;
    tick();
    set_add(5'd5);
    in_f.memwrite = 2'b10;
    in_flush = 1'b1; in_stall = 1'b1;
    #1;
    n_tests++;
    if (bus.id_hold_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_hold: got %b want 0", bus.id_hold_o);
    end
    tick();
    n_tests++;
    if (bus.ex_valid !== 1'b0 || bus.ex_MemWrite !== 2'b00 || ex_fields() !== fields_t'(0)) begin
      n_fail++;
      $display("FAIL flush_bubble: got v=%b mw=%b f=%h want v=0 mw=00 f=0",
               bus.ex_valid, bus.ex_MemWrite, ex_fields());
    end
`ifdef HAZARD_PERF_EN
    n_tests++;
    if (perf_fl !== 32'd1 || perf_lu !== 32'd0) begin
      n_fail++; $display("FAIL flush_perf: got fl=%0d lu=%0d want fl=1 lu=0", perf_fl, perf_lu);
    end
`endif
    in_flush = 1'b0; in_stall = 1'b0;
  endtask

  task automatic test_reset_mid_hazard();
    apply_reset();
    set_load();
    tick();
    set_add(5'd5);
    #1;
    rst = 1'b1;
    #1;
    m_valid = 1'b0; m_f = '0; m_lu = 0; m_fl = 0;
    n_tests++;
    if (bus.ex_valid !== 1'b0 || ex_fields() !== fields_t'(0) || bus.id_hold_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: got v=%b f=%h hold=%b want all 0", bus.ex_valid, ex_fields(), bus.id_hold_o);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_tests++;
    if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 32'h204) begin
      n_fail++; $display("FAIL rst_recover: got v=%b pc=%h want v=1 pc=204", bus.ex_valid, bus.ex_pc);
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      in_f = rand_fields();
      in_f.memread = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 2) == 0) in_f.rs1 = m_f.rd;
      if ($urandom_range(0, 3) == 0) in_f.rs2 = m_f.rd;
      in_valid = ($urandom_range(0, 3) != 0);
      in_flush = ($urandom_range(0, 7) == 0);
      in_stall = ($urandom_range(0, 4) == 0);
      #1;
      n_tests++;
      if (bus.id_hold_o !== (!in_flush && (in_stall || model_hazard()))) begin
        n_fail++; errs++;
        if (errs < 10) $display("FAIL rand_hold[%0d]: got %b want %b", i, bus.id_hold_o,
                                (!in_flush && (in_stall || model_hazard())));
      end
      tick();
      n_tests++;
      if (bus.ex_valid !== m_valid || ex_fields() !== m_f) begin
        n_fail++; errs++;
        if (errs < 10) $display("FAIL rand_ex[%0d]: got v=%b f=%h want v=%b f=%h",
                                i, bus.ex_valid, ex_fields(), m_valid, m_f);
      end
    end
    in_flush = 1'b0; in_stall = 1'b0; in_valid = 1'b0;
`ifdef HAZARD_PERF_EN
    n_tests++;
    if (perf_lu !== m_lu || perf_fl !== m_fl) begin
      n_fail++; $display("FAIL rand_perf: got lu=%0d fl=%0d want lu=%0d fl=%0d", perf_lu, perf_fl, m_lu, m_fl);
    end
`endif
  endtask

  initial begin
    m_valid = 1'b0; m_f = '0; m_lu = 0; m_fl = 0;
    rst = 1'b1;
    #12;
    rst = 1'b0;
    test_reset();
    test_basic();
    test_load_use();
    test_x0();
    test_stall();
    test_flush_priority();
    test_reset_mid_hazard();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
